// File: rtl/alu_sched_if.sv
// Requester-side request/response bundle for alu_sched: per-requester
// valid/ready request channel plus one-hot response channel with a shared data bus.
interface alu_sched_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]                 req_valid_i;
    logic [NUM_REQ-1:0]                 req_ready_o;
    logic [NUM_REQ-1:0][1:0]            req_op_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a_i;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b_i;
    logic [NUM_REQ-1:0]                 rsp_valid_o;
    logic [NUM_REQ-1:0]                 rsp_ready_i;
    logic [DATA_WIDTH-1:0]              rsp_data_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/alu_sched.sv
// Purpose: time-multiplexes one external combinational ALU across NUM_REQ requesters.
// Latency: accept in T, ALU driven in T+1, response valid from T+2; 3-cycle minimum period.
// Backpressure: response held with stable data until the owner's rsp_ready_i; no accepts meanwhile.
// ALU_SCHED_FIXED_PRIO_EN: lowest-index fixed priority instead of round-robin.
module alu_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_sched_if.slave            req_if,
    output logic [1:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_c_i,
    output logic                  busy_o
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]            op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
    } opnd_t;

    state_e                state_q, state_d;
    opnd_t                 opnd_q, opnd_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [IDW-1:0]        id_q, id_d;
    logic [NUM_REQ-1:0]    rsp_vld_q, rsp_vld_d;
    logic                  busy_q, busy_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW:0]          cand;
`endif

    logic                  gnt_vld;
    logic [IDW-1:0]        gnt_id;
    logic [NUM_REQ-1:0]    req_rdy;

    // Descending scan so the last hit is the highest-priority candidate.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_if.req_valid_i[IDW'(i)]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(i);
            end
        end
`else
        cand = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (req_if.req_valid_i[cand[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand[IDW-1:0];
            end
        end
`endif
    end

    always_comb begin
        req_rdy = '0;
        if (rst_n && (state_q == IDLE) && gnt_vld) begin
            req_rdy[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        res_d     = res_q;
        id_d      = id_q;
        rsp_vld_d = rsp_vld_q;
        busy_d    = busy_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    opnd_d.op = req_if.req_op_i[gnt_id];
                    opnd_d.a  = req_if.req_a_i[gnt_id];
                    opnd_d.b  = req_if.req_b_i[gnt_id];
                    id_d      = gnt_id;
                    busy_d    = 1'b1;
                    state_d   = EXEC;
`ifndef ALU_SCHED_FIXED_PRIO_EN
                    ptr_d     = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
`endif
                end
            end
            EXEC: begin
                // Operand registers double as the ALU drive, so clear them once consumed.
                res_d           = alu_c_i;
                opnd_d          = '0;
                rsp_vld_d       = '0;
                rsp_vld_d[id_q] = 1'b1;
                state_d         = RESP;
            end
            RESP: begin
                if (req_if.rsp_ready_i[id_q]) begin
                    rsp_vld_d = '0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            opnd_q    <= '0;
            res_q     <= '0;
            id_q      <= '0;
            rsp_vld_q <= '0;
            busy_q    <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            res_q     <= res_d;
            id_q      <= id_d;
            rsp_vld_q <= rsp_vld_d;
            busy_q    <= busy_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign req_if.req_ready_o = req_rdy;
    assign req_if.rsp_valid_o = rsp_vld_q;
    assign req_if.rsp_data_o  = res_q;
    assign alu_op_o           = opnd_q.op;
    assign alu_a_o            = opnd_q.a;
    assign alu_b_o            = opnd_q.b;
    assign busy_o             = busy_q;

endmodule

// File: doc/alu_sched.md
# alu_sched

Time-multiplexed scheduler sharing one combinational `alu` instance between `NUM_REQ` requesters. Accepts one operation at a time through per-requester valid/ready, drives the ALU from registered operands, captures the result and returns it to the originating requester with a response handshake. Sits between the requester ports and the `alu` `op_i`/`data_a_i`/`data_b_i`/`data_c_o` ports.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must match the shared ALU.
- `NUM_REQ`, 4, number of requesters, 2..16.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  NUM_REQ  request pending per requester.
- `req_ready_o`  out  NUM_REQ  one-hot accept strobe.
- `req_op_i`  in  NUM_REQ x 2  opcode per requester: 00 add, 01 sub, 10 xor, 11 and.
- `req_a_i`, `req_b_i`  in  NUM_REQ x DATA_WIDTH  operands per requester.
- `rsp_valid_o`  out  NUM_REQ  one-hot response valid.
- `rsp_ready_i`  in  NUM_REQ  response accept per requester.
- `rsp_data_o`  out  DATA_WIDTH  shared result bus; meaningful only with `rsp_valid_o`.
- `alu_op_o`  out  2  to ALU `op_i`.
- `alu_a_o`, `alu_b_o`  out  DATA_WIDTH  to ALU `data_a_i`/`data_b_i`.
- `alu_c_i`  in  DATA_WIDTH  from ALU `data_c_o`.
- `busy_o`  out  1  high whenever state is not IDLE.

## Operation
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: if any `req_valid_i`, arbiter picks winner `w`; `req_ready_o[w]` = 1 combinationally that cycle (all others 0); on the clock edge latch op/a/b and `w` into internal registers, go to EXEC. No valid: stay, all ready 0.
- EXEC: `alu_op_o/alu_a_o/alu_b_o` driven from latched registers (zero in all other states); `alu_c_i` registered into result register; go to RESP.
- RESP: `rsp_valid_o[w]` = 1, `rsp_data_o` = result register held stable. On `rsp_ready_i[w]` = 1: go to IDLE. `rsp_ready_i` of other requesters ignored. No request accepted while in EXEC or RESP.
- Arbitration (default): round-robin. Pointer `ptr` resets to 0; search starts at `ptr`, ascending with wrap; after a grant, `ptr` = (w+1) mod NUM_REQ. Pointer advances only on grant.
- Arithmetic: result is DATA_WIDTH bits, carry/borrow discarded (wrap modulo 2^DATA_WIDTH). Sub is a - b.
- Requester rules: once `req_valid_i` is high it holds op/operands until ready; dropping valid before grant is legal and loses nothing.
- Reset (any state, async): state IDLE, `ptr` 0, latched op/operands/result/id cleared, in-flight operation discarded with no response.

## Timing
- Reset values: `req_ready_o` 0, `rsp_valid_o` 0, `rsp_data_o` 0, `alu_*_o` 0, `busy_o` 0.
- Accept in cycle T (ready high); ALU driven in T+1; `rsp_valid_o` high from T+2.
- Minimum per-operation period 3 cycles (response accepted in T+2, next accept T+3).
- `req_ready_o` depends combinationally on `req_valid_i` and state; all other outputs are registered-state decodes.
- Response held indefinitely under backpressure; `rsp_data_o` does not change while `rsp_valid_o` high.

## Configuration
- `ALU_SCHED_FIXED_PRIO_EN`: when defined, arbitration is fixed priority, lowest index wins, `ptr` logic removed. When undefined, round-robin as above.

## Test plan
- Single add: req0 op 00 a=0xFFFF_FFFF b=0x1, accepted cycle T -> `rsp_valid_o`=0001 at T+2, `rsp_data_o`=0x0000_0000.
- Op coverage on req2: sub 5-7 -> 0xFFFF_FFFE; xor 0xF0F0_F0F0^0xFF00_FF00 -> 0x0FF0_0FF0; and same operands -> 0xF000_F000; each response on `rsp_valid_o[2]` only.
- Round-robin: all four valid continuously from reset, `rsp_ready_i` tied high -> grants 0,1,2,3,0,1 each 3 cycles apart; with `ALU_SCHED_FIXED_PRIO_EN` -> grants 0,0,0...
- Backpressure: req1 response, `rsp_ready_i[1]` low 4 cycles, req3 valid meanwhile -> data stable, `req_ready_o[3]` stays 0, req3 granted the cycle after req1 handshake.
- Wrong-port ready: in RESP for req1, assert `rsp_ready_i[0]` only -> state unchanged, `rsp_valid_o[1]` stays high.
- Reset mid-op: assert `rst_n`=0 during EXEC -> all outputs 0 immediately, no response after release; next grant starts at req0.
